fp13_accum_add: RTL and testbench

Multicycle 13-bit floating-point adder forming the accumulate half of the systolic-array MAC PE. Sits directly downstream of `mul_multicycle`: it takes that block's 13-bit product plus the running partial sum, and returns the rounded 13-bit sum with overflow and rounding-loss flags. It uses the same `start`/`stop` handshake as the multiplier, so the PE control can chain the two without glue logic.

---
 rtl/fp13_pkg.sv | 23 ++
 rtl/lzc12.sv | 15 +
 rtl/fp13_accum_add.sv | 177 +++++++++++++++++
 tb/tb_fp13_accum_add.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fp13_pkg.sv
// rtl/fp13_pkg.sv - shared fp13 types and constants for the MAC PE multiplier and adder
package fp13_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [6:0] man;
    } fp13_t;

    localparam int          FP13_BIAS    = 15;
    localparam int          FP13_EXP_MAX = 30;
    localparam logic [11:0] FP13_MAX_MAG = 12'hF7F;

    typedef enum logic [2:0] {
        ADD_IDLE,
        ADD_ALIGN,
        ADD_ADD,
        ADD_NORM,
        ADD_ROUND,
        ADD_DONE
    } add_state_e;

endpackage

// File: rtl/lzc12.sv
// rtl/lzc12.sv - combinational 12-bit leading-zero counter (12 when the input is zero)
module lzc12 (
    input  logic [11:0] value,
    output logic [3:0]  count
);

    // Scan upward so the highest set bit makes the final assignment.
    always_comb begin
        count = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (value[i]) count = 4'(11 - i);
        end
    end

endmodule

// File: rtl/fp13_accum_add.sv
// rtl/fp13_accum_add.sv - multicycle fp13 accumulate adder; FP13_ADD_RNE_EN selects RNE over truncation
module fp13_accum_add
    import fp13_pkg::*;
#(
    parameter int MAX_ALIGN = 10
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic        stop,
    input  logic [12:0] op1,
    input  logic [12:0] op2,
    output logic [12:0] out,
    output logic        done,
    output logic        overflow,
    output logic        round_loss
);

    localparam int CW = $clog2(MAX_ALIGN + 2);

    add_state_e state_q, state_d;

    fp13_t             a_op, b_op, hi;
    logic              a_zero, b_zero, a_big, collapse;
    logic [4:0]        lo_exp, d;
    logic [6:0]        lo_man;
    logic [10:0]       hi_m, lo_m;
    logic [CW-1:0]     k_in;

    logic              sign_q, sub_q, zero_q;
    logic signed [6:0] exp_q;
    logic [10:0]       big_q, small_q, mant_q;
    logic [11:0]       sum_q;
    logic [CW-1:0]     cnt_q;

    logic [3:0]        lz, sh;
    logic [10:0]       norm_m;
    logic signed [6:0] norm_e;

    logic              inc, loss;
    logic [8:0]        rsum;
    logic [6:0]        man7;
    logic signed [6:0] exp_r;
    logic [12:0]       rnd_out;
    logic              rnd_ovf, rnd_loss;

    assign a_op = op1;
    assign b_op = op2;
    assign done = (state_q == ADD_DONE);

    // A zero operand has no meaningful exponent, so it needs no alignment.
    always_comb begin
        a_zero   = (a_op.exp == 5'd0);
        b_zero   = (b_op.exp == 5'd0);
        a_big    = b_zero || (!a_zero && ({a_op.exp, a_op.man} >= {b_op.exp, b_op.man}));
        hi       = a_big ? a_op : b_op;
        lo_exp   = a_big ? b_op.exp : a_op.exp;
        lo_man   = a_big ? b_op.man : a_op.man;
        hi_m     = (hi.exp == 5'd0) ? 11'd0 : {1'b1, hi.man, 3'b000};
        lo_m     = (lo_exp == 5'd0) ? 11'd0 : {1'b1, lo_man, 3'b000};
        d        = (a_zero || b_zero) ? 5'd0 : hi.exp - lo_exp;
        collapse = int'(d) > MAX_ALIGN;
        k_in     = collapse ? CW'(MAX_ALIGN) : CW'(d);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state_q <= ADD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ADD_IDLE:  if (start) state_d = (k_in != '0) ? ADD_ALIGN : ADD_ADD;
            ADD_ALIGN: if (cnt_q == CW'(1)) state_d = ADD_ADD;
            ADD_ADD:   state_d = ADD_NORM;
            ADD_NORM:  state_d = ADD_ROUND;
            ADD_ROUND: state_d = ADD_DONE;
            ADD_DONE:  if (stop) state_d = ADD_IDLE;
            default:   state_d = ADD_IDLE;
        endcase
    end

    lzc12 u_lzc (
        .value (sum_q),
        .count (lz)
    );

    always_comb begin
        sh = lz - 4'd1;
        if (sum_q[11]) begin
            norm_m = {sum_q[11:2], |sum_q[1:0]};
            norm_e = exp_q + 7'sd1;
        end else begin
            norm_m = 11'(sum_q << sh);
            norm_e = exp_q - $signed({3'b000, sh});
        end
    end

    always_comb begin
        loss = |mant_q[2:0];
`ifdef FP13_ADD_RNE_EN
        inc  = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
`else
        inc  = 1'b0;
`endif
        // A rounding carry-out means the mantissa became exactly 10.0000000.
        rsum  = {1'b0, mant_q[10:3]} + {8'd0, inc};
        man7  = rsum[8] ? rsum[7:1] : rsum[6:0];
        exp_r = exp_q + $signed({6'd0, rsum[8]});

        rnd_out  = 13'd0;
        rnd_ovf  = 1'b0;
        rnd_loss = loss;
        if (zero_q) begin
            rnd_loss = 1'b0;
        end else if (exp_r > $signed(7'(FP13_EXP_MAX))) begin
            rnd_out = {sign_q, FP13_MAX_MAG};
            rnd_ovf = 1'b1;
        end else if (exp_r <= 7'sd0) begin
            rnd_out  = {sign_q, 12'h000};
            rnd_loss = 1'b1;
        end else begin
            rnd_out = {sign_q, exp_r[4:0], man7};
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            zero_q     <= 1'b0;
            exp_q      <= 7'sd0;
            big_q      <= 11'd0;
            small_q    <= 11'd0;
            mant_q     <= 11'd0;
            sum_q      <= 12'd0;
            cnt_q      <= '0;
            out        <= 13'd0;
            overflow   <= 1'b0;
            round_loss <= 1'b0;
        end else begin
            case (state_q)
                ADD_IDLE: if (start) begin
                    sign_q     <= hi.sign;
                    sub_q      <= a_op.sign ^ b_op.sign;
                    exp_q      <= $signed({2'b00, hi.exp});
                    big_q      <= hi_m;
                    small_q    <= collapse ? {10'd0, |lo_m} : lo_m;
                    cnt_q      <= k_in;
                    overflow   <= 1'b0;
                    round_loss <= 1'b0;
                end
                ADD_ALIGN: begin
                    small_q <= {1'b0, small_q[10:2], |small_q[1:0]};
                    cnt_q   <= cnt_q - CW'(1);
                end
                ADD_ADD: begin
                    sum_q <= sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                   : ({1'b0, big_q} + {1'b0, small_q});
                end
                ADD_NORM: begin
                    mant_q <= norm_m;
                    exp_q  <= norm_e;
                    zero_q <= (sum_q == 12'd0);
                end
                ADD_ROUND: begin
                    out        <= rnd_out;
                    overflow   <= rnd_ovf;
                    round_loss <= rnd_loss;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp13_accum_add.sv
// tb/tb_fp13_accum_add.sv - directed vector bench for fp13_accum_add
module tb_fp13_accum_add;

    logic        tb_clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [12:0] op1;
    logic [12:0] op2;
    logic [12:0] sum_out;
    logic        done;
    logic        overflow;
    logic        round_loss;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [12:0] a;
        logic [12:0] b;
        logic [12:0] res;
        logic        ovf;
        logic        loss;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    fp13_accum_add #(.MAX_ALIGN(10)) dut (
        .clk        (tb_clk),
        .nRST       (rst_n),
        .start      (start),
        .stop       (stop),
        .op1        (op1),
        .op2        (op2),
        .out        (sum_out),
        .done       (done),
        .overflow   (overflow),
        .round_loss (round_loss)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string name);
        int lat;
        @(posedge tb_clk); #1;
        op1   = v.a;
        op2   = v.b;
        start = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        check({name, "_flags_clr"}, {30'd0, overflow, round_loss}, 32'd0);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge tb_clk); #1;
            lat++;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        if (v.lat != 0) check({name, "_latency"}, lat, v.lat);
        check({name, "_out"}, {19'd0, sum_out}, {19'd0, v.res});
        check({name, "_overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
        check({name, "_round_loss"}, {31'd0, round_loss}, {31'd0, v.loss});
        stop = 1'b1;
        @(posedge tb_clk); #1;
        stop = 1'b0;
        check({name, "_done_fall"}, {31'd0, done}, 32'd0);
        check({name, "_out_hold"}, {19'd0, sum_out}, {19'd0, v.res});
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        op1   = 13'd0;
        op2   = 13'd0;

        //                a         b         result    ovf   loss  lat
        vecs[0]  = '{13'h0780, 13'h0780, 13'h0800, 1'b0, 1'b0, 3};
        vecs[1]  = '{13'h0780, 13'h1780, 13'h0000, 1'b0, 1'b0, 3};
        vecs[2]  = '{13'h0780, 13'h0700, 13'h07C0, 1'b0, 1'b0, 4};
        vecs[3]  = '{13'h0F7F, 13'h0F7F, 13'h0F7F, 1'b1, 1'b0, 3};
        vecs[4]  = '{13'h0F7F, 13'h0F00, 13'h0F7F, 1'b1, 1'b1, 3};
        vecs[5]  = '{13'h0780, 13'h0180, 13'h0780, 1'b0, 1'b1, 13};
        vecs[6]  = '{13'h0780, 13'h1740, 13'h0680, 1'b0, 1'b0, 4};
        vecs[7]  = '{13'h0780, 13'h0380, 13'h0780, 1'b0, 1'b1, 11};
        vecs[8]  = '{13'h17C0, 13'h17C0, 13'h1840, 1'b0, 1'b0, 3};
        vecs[9]  = '{13'h0000, 13'h1234, 13'h1234, 1'b0, 1'b0, 0};
        vecs[10] = '{13'h10C0, 13'h0080, 13'h1000, 1'b0, 1'b1, 3};

        repeat (3) @(posedge tb_clk);
        #1;
        check("reset_out", {19'd0, sum_out}, 32'd0);
        check("reset_flags", {29'd0, done, overflow, round_loss}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // Reset two cycles into an operation aborts it without a clock edge.
        @(posedge tb_clk); #1;
        op1   = 13'h0F7F;
        op2   = 13'h0F00;
        start = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        @(posedge tb_clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out", {19'd0, sum_out}, 32'd0);
        check("abort_flags", {29'd0, done, overflow, round_loss}, 32'd0);
        @(posedge tb_clk); #1;
        rst_n = 1'b1;
        v = '{13'h0780, 13'h0780, 13'h0800, 1'b0, 1'b0, 3};
        run_op(v, "after_abort");

        // DONE is held until stop; start together with stop is not a capture.
        @(posedge tb_clk); #1;
        op1   = 13'h0780;
        op2   = 13'h0780;
        start = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        for (int w = 0; w < 40 && !done; w++) begin
            @(posedge tb_clk); #1;
        end
        check("hold_done_rise", {31'd0, done}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge tb_clk); #1;
            check($sformatf("hold_done_c%0d", c), {31'd0, done}, 32'd1);
        end
        op1   = 13'h0700;
        op2   = 13'h0700;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge tb_clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_done_fall", {31'd0, done}, 32'd0);
        repeat (5) @(posedge tb_clk);
        #1;
        check("startstop_no_capture", {31'd0, done}, 32'd0);
        check("startstop_out_hold", {19'd0, sum_out}, 32'h0800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
